// File: rtl/neuron_pkg.sv
// Shared types and widths for the spiking-neuron datapath: current width,
// weight record layout and synapse fan-in.
package neuron_pkg;
    localparam int CUR_W  = 4;
    localparam int CUR_MAX = 15;
    localparam int WT_W   = 4;
    localparam int NUM_IN = 4;
    localparam int SUM_W  = 8;

    typedef struct packed {
        logic            inh;
        logic [WT_W-1:0] mag;
    } weight_t;
endpackage

// File: rtl/spike_synapse_syn_sum.sv
// Combinational weighted spike sum: signed (excitatory - inhibitory) magnitude
// over all inputs that spiked this cycle.
module syn_sum
    import neuron_pkg::*;
(
    input  logic                    [NUM_IN-1:0] spk_in,
    input  weight_t                 [NUM_IN-1:0] weights,
    output logic signed [SUM_W-1:0]              net
);
    logic signed [SUM_W-1:0] contrib [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        logic signed [SUM_W-1:0] mag_s;
        assign mag_s      = SUM_W'(weights[i].mag);
        assign contrib[i] = !spk_in[i]      ? '0 :
                            weights[i].inh  ? -mag_s : mag_s;
    end

    always_comb begin
        net = '0;
        for (int i = 0; i < NUM_IN; i++)
            net = net + contrib[i];
    end
endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current synapse: weighted spike sum into a halving, saturating
// current register, plus a windowed spike-rate counter.
module spike_synapse
    import neuron_pkg::*;
#(
    parameter int W_INIT   = 4,
    parameter int WIN_LOG2 = 4,
    parameter int RATE_W   = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [NUM_IN-1:0] spk_in,
    input  logic              wt_valid,
    input  logic [1:0]        wt_addr,
    input  logic [4:0]        wt_data,
    output logic              wt_ready,
    output logic [CUR_W-1:0]  current,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid
);
    localparam int POP_W = $clog2(NUM_IN + 1);
    localparam logic [WIN_LOG2-1:0]   WIN_LAST  = '1;
    localparam logic [RATE_W-1:0]     RATE_MAX  = '1;
    localparam logic signed [SUM_W-1:0] CUR_MAX_S = SUM_W'(CUR_MAX);
    localparam weight_t W_RESET = '{inh: 1'b0, mag: WT_W'(W_INIT)};

    weight_t [NUM_IN-1:0]    weights;
    logic signed [SUM_W-1:0] net, half, acc_next;
    logic [CUR_W-1:0]        cur_clamped;
    logic [WIN_LOG2-1:0]     win_cnt;
    logic [RATE_W-1:0]       run, run_sat;
    logic [RATE_W:0]         run_sum;
    logic [POP_W-1:0]        pop;

    syn_sum u_sum (
        .spk_in  (spk_in),
        .weights (weights),
        .net     (net)
    );

    // Sum is at most 7 + 60, so 8-bit signed never wraps before the clamp.
    always_comb begin
        half     = SUM_W'(current >> 1);
        acc_next = half + net;
        if (acc_next < 0)
            cur_clamped = '0;
        else if (acc_next > CUR_MAX_S)
            cur_clamped = CUR_W'(CUR_MAX);
        else
            cur_clamped = acc_next[CUR_W-1:0];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_IN; i++)
            pop = pop + POP_W'(spk_in[i]);
        run_sum = {1'b0, run} + (RATE_W+1)'(pop);
        run_sat = run_sum[RATE_W] ? RATE_MAX : run_sum[RATE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wt_ready   <= 1'b0;
            weights    <= {NUM_IN{W_RESET}};
            current    <= '0;
            win_cnt    <= '0;
            run        <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            wt_ready   <= 1'b1;
            rate_valid <= 1'b0;
            // The accumulator reads the pre-edge weights, so a same-cycle
            // write only affects spikes from the next edge on.
            if (wt_valid && wt_ready)
                weights[wt_addr] <= weight_t'(wt_data);
            if (en) begin
                current <= cur_clamped;
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == WIN_LAST) begin
                    rate       <= run_sat;
                    run        <= '0;
                    rate_valid <= 1'b1;
                end else begin
                    run <= run_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed vector table, hand-written
// rate/enable/reset sequences and a randomized run against an arithmetic model.
module tb_spike_synapse;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       en = 0;
    logic [3:0] spk_in = 0;
    logic       wt_valid = 0;
    logic [1:0] wt_addr = 0;
    logic [4:0] wt_data = 0;
    logic       wt_ready;
    logic [3:0] current;
    logic [5:0] rate;
    logic       rate_valid;

    spike_synapse dut (
        .clk(clk), .reset_n(reset_n), .en(en), .spk_in(spk_in),
        .wt_valid(wt_valid), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_ready(wt_ready), .current(current), .rate(rate), .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state
    int m_cur, m_rate, m_rv, m_win, m_run, m_rdy;
    int m_mag [4];
    int m_inh [4];

    typedef struct {
        bit       rst;
        bit       en;
        bit [3:0] spk;
        bit       wv;
        bit [1:0] wa;
        bit [4:0] wd;
        int       cur;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit rst, bit e, bit [3:0] s, bit wv, bit [1:0] wa, bit [4:0] wd, int cur);
        vec_t v;
        v.rst = rst; v.en = e; v.spk = s; v.wv = wv; v.wa = wa; v.wd = wd; v.cur = cur;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit e, input bit [3:0] s,
                              input bit wv, input bit [1:0] wa, input bit [4:0] wd);
        int exc, inh, nx, pc;
        if (rst) begin
            m_cur = 0; m_rate = 0; m_rv = 0; m_win = 0; m_run = 0; m_rdy = 0;
            for (int i = 0; i < 4; i++) begin m_mag[i] = 4; m_inh[i] = 0; end
            return;
        end
        m_rv = 0;
        if (e) begin
            exc = 0; inh = 0; pc = 0;
            for (int i = 0; i < 4; i++) if (s[i]) begin
                pc++;
                if (m_inh[i] != 0) inh += m_mag[i]; else exc += m_mag[i];
            end
            nx = m_cur / 2 + exc - inh;
            m_cur = nx < 0 ? 0 : (nx > 15 ? 15 : nx);
            m_run = m_run + pc;
            if (m_run > 63) m_run = 63;
            if (m_win == 15) begin
                m_rate = m_run; m_run = 0; m_rv = 1;
            end
            m_win = (m_win + 1) % 16;
        end
        if (wv && m_rdy != 0) begin
            m_mag[wa] = int'(wd[3:0]);
            m_inh[wa] = int'(wd[4]);
        end
        m_rdy = 1;
    endtask

    // Drive one cycle, update the model at the edge, then compare all outputs.
    task automatic step(input bit rst, input bit e, input bit [3:0] s,
                        input bit wv, input bit [1:0] wa, input bit [4:0] wd);
        reset_n = !rst; en = e; spk_in = s; wt_valid = wv; wt_addr = wa; wt_data = wd;
        @(posedge clk);
        model_edge(rst, e, s, wv, wa, wd);
        #1;
        chk("current", int'(current), m_cur);
        chk("rate", int'(rate), m_rate);
        chk("rate_valid", int'(rate_valid), m_rv);
        chk("wt_ready", int'(wt_ready), m_rdy);
    endtask

    task automatic idle(input bit [3:0] s);
        step(0, 1, s, 0, 0, 0);
    endtask

    initial begin
        int held_cur, pulses;
        #1;
        // Directed table: each entry's current is a hand-derived constant.
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 15));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 7));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 1, 5'b11111, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 1, 0, 5'b01001, 4));
        tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 11));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].spk, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            chk($sformatf("tbl%0d_current", i), int'(current), tbl[i].cur);
        end

        // Rate window: two spikes per cycle gives 32 per 16-cycle window.
        step(1, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int c = 1; c <= 32; c++) begin
            idle(4'b0011);
            chk($sformatf("rv_c%0d", c), int'(rate_valid), (c % 16 == 0) ? 1 : 0);
            if (rate_valid) begin
                pulses++;
                chk("rate_32", int'(rate), 32);
            end
        end
        chk("rate_pulses", pulses, 2);
        for (int c = 1; c <= 16; c++) idle(4'b1111);
        chk("rate_sat_valid", int'(rate_valid), 1);
        chk("rate_sat", int'(rate), 63);

        // en low mid-window: everything holds, spikes ignored.
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) idle(4'b0011);
        held_cur = int'(current);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 4'b1111, 0, 0, 0);
            chk("en0_current_hold", int'(current), held_cur);
            chk("en0_rv_low", int'(rate_valid), 0);
        end
        for (int c = 0; c < 10; c++) idle(4'b0011);
        chk("en0_rv_not_yet", int'(rate_valid), 0);
        idle(4'b0011);
        chk("en0_window_end", int'(rate_valid), 1);
        chk("en0_rate", int'(rate), 32);

        // Reset mid-window after a weight change restores weights and clears state.
        idle(4'b0000);
        step(0, 1, 4'b0000, 1, 0, 5'b01001);
        for (int c = 0; c < 3; c++) idle(4'b0101);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_current", int'(current), 0);
        chk("rst_rate", int'(rate), 0);
        idle(4'b0000);
        idle(4'b0001);
        chk("rst_weight_back", int'(current), 4);
        for (int c = 0; c < 13; c++) idle(4'b0000);
        chk("rst_partial_discard_rv", int'(rate_valid), 0);
        idle(4'b0000);
        chk("rst_partial_discard_valid", int'(rate_valid), 1);
        chk("rst_partial_discard_rate", int'(rate), 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
                 4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
- Converts presynaptic spike trains back into the 4-bit current that drives a downstream LIF neuron.
- Four spike inputs, each with a programmable 4-bit weight and a polarity bit (excitatory or inhibitory).
- The weighted sum feeds a leaky, saturating current register whose leak matches the neuron's halving leak.
- Also reports a windowed spike-rate count for observability and rate decoding.
- Sits between one layer's neuron spike outputs and the next layer's neuron current inputs.

Parameters:
- NUM_IN, 4, number of presynaptic spike inputs; fixed at 4 for this revision.
- W_INIT, 4, reset weight magnitude for every input; all inputs reset excitatory.
- WIN_LOG2, 4, log2 of the rate window length in cycles (default window is 16 cycles).
- RATE_W, 6, width of the rate counter and the rate output.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- en  in  1  advance enable; when low, accumulator and window logic hold
- spk_in  in  NUM_IN  presynaptic spikes, sampled on the rising edge of clk
- wt_valid  in  1  weight-write request
- wt_addr  in  2  index of the input whose weight is written
- wt_data  in  5  bit4 = inhibitory flag, bits3:0 = magnitude
- wt_ready  out  1  weight-write accept
- current  out  4  synaptic current to the neuron
- rate  out  RATE_W  spike count of the last completed window
- rate_valid  out  1  one-cycle pulse when rate updates

Behaviour:
- Reset (reset_n low at a clk edge):
  - current=0, rate=0, rate_valid=0, window counter=0, running count=0.
  - All weights = {0, W_INIT}; wt_ready=0.
  - Reset asserted mid-window discards the partial count.
- wt_ready = 1 on every cycle after the first non-reset edge.
- Weight write occurs when wt_valid & wt_ready at an edge:
  - weight[wt_addr] <= wt_data.
  - Writes are independent of en.
  - A spike on the same input in the same cycle uses the OLD weight; the new weight applies from the next edge.
- Accumulator update, when en=1 at an edge:
  - exc = sum of magnitudes of excitatory inputs with spk_in set (range 0..60).
  - inh = the same sum over inhibitory inputs (range 0..60).
  - next = (current >> 1) + exc - inh, evaluated in at least 8-bit signed arithmetic; no intermediate wrap.
  - current <= clamp(next, 0, 15).
- Accumulator latency: a spike sampled at edge k is reflected in current after edge k; current is a registered output.
- en=0: current, the window counter and the running count hold; spikes in that cycle are ignored.
- Rate window, when en=1:
  - win_cnt increments and wraps at 2^WIN_LOG2 - 1.
  - run = run + popcount(spk_in), saturating at 2^RATE_W - 1.
  - On the edge where win_cnt == 2^WIN_LOG2 - 1:
    - rate <= saturated run including this cycle's spikes;
    - run <= 0;
    - rate_valid <= 1 for exactly that following cycle.
  - rate_valid is 0 on every other cycle, including while en=0.
- Simultaneous weight write, spikes and window end: all three take effect at the same edge, each per the rules above.
- current never exceeds 15 and never goes below 0; rate never wraps.

Decomposition:
- Shared package (neuron_pkg):
  - CUR_W=4 and CUR_MAX=15;
  - WT_W=4 and the weight record layout (inh flag plus magnitude);
  - NUM_IN=4.
- Sub-module syn_sum: combinational weighted sum that produces signed exc - inh from spk_in and the weight array. Keeps the top level to registers, the window counter and the clamp logic.

Test Plan:
- Reset, then spk_in=0001 for 1 cycle, then 0000 -> current sequence 4, 2, 1, 0.
- Reset, then spk_in=1111 for 1 cycle -> current=15 (16 saturates); next idle cycles give 7, 3, 1, 0.
- Write weight[1]={1,15}; build current=4 with spk_in=0001; then spk_in=0010 -> current=0 (2-15 clamps).
- Write weight[0]={0,9} with spk_in=0001 in the same cycle -> current=4 (old weight); repeat the spike next cycle -> 2+9=11.
- spk_in=0011 on every cycle with en=1 -> rate=32 and rate_valid=1 on exactly the cycle after the 16th edge, then every 16 cycles; with spk_in=1111, rate saturates at 63.
- en=0 for 5 cycles mid-window with spikes present -> current, run and window position unchanged; reset_n low mid-window -> rate=0, current=0, weights back to 4.
